// File: rtl/cond_pkg.sv
// Shared types for the conditional-execution unit: condition codes, the NZCV
// flag layout and the predicated-block state encoding.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } it_state_e;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM-style condition evaluator: does cond hold for the given NZCV?
module cond_check
  import cond_pkg::*;
(
  input  cond_e  cond,
  input  flags_t flags,
  output logic   holds
);

  // Decode the condition against the flag bits
  always_comb begin
    holds = 1'b0;
    case (cond)
      EQ: holds = flags.z;
      NE: holds = ~flags.z;
      CS: holds = flags.c;
      CC: holds = ~flags.c;
      MI: holds = flags.n;
      PL: holds = ~flags.n;
      VS: holds = flags.v;
      VC: holds = ~flags.v;
      HI: holds = flags.c & ~flags.z;
      LS: holds = ~flags.c | flags.z;
      GE: holds = (flags.n == flags.v);
      LT: holds = (flags.n != flags.v);
      GT: holds = ~flags.z & (flags.n == flags.v);
      LE: holds = flags.z | (flags.n != flags.v);
      AL: holds = 1'b1;
      NV: holds = 1'b0;
      default: holds = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_unit.sv
// Execute-stage conditional-execution unit: NZCV register, request gating and
// a counter-driven predicated-block tracker.
module cond_exec_unit
  import cond_pkg::*;
#(
  parameter int MAX_IT = 4,
  parameter int CNT_W  = $clog2(MAX_IT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instrValid,
  input  logic             stall,
  input  logic [3:0]       cond,
  input  logic             pcsReq,
  input  logic             regWReq,
  input  logic             memWReq,
  input  logic [1:0]       flagWriteReq,
  input  logic [3:0]       aluFlags,
  input  logic             itStart,
  input  logic [3:0]       itCond,
  input  logic [CNT_W-1:0] itLen,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             condEx,
  output logic [3:0]       flags,
  output logic             itActive,
  output logic [CNT_W-1:0] itRemaining,
  output logic             itErr
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_IT);

  it_state_e        state, state_nxt;
  logic [CNT_W-1:0] counter, counter_nxt;
  logic [3:0]       it_cond, it_cond_nxt;
  logic             it_err, it_err_nxt;
  flags_t           flags_q;
  logic             accept;
  logic [3:0]       eff_cond;
  logic             holds;

  assign accept   = instrValid & ~stall;
  assign eff_cond = (state == ACTIVE) ? it_cond : cond;

  cond_check u_cond_check (
    .cond  (cond_e'(eff_cond)),
    .flags (flags_q),
    .holds (holds)
  );

  assign condEx      = accept & holds & ~itStart;
  assign PCSrc       = pcsReq & condEx;
  assign RegWrite    = regWReq & condEx;
  assign MemWrite    = memWReq & condEx;
  assign flags       = flags_q;
  assign itActive    = (state == ACTIVE);
  assign itRemaining = counter;
  assign itErr       = it_err;

  // Flag register with independent N/Z and C/V write groups
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
    end else if (condEx) begin
      if (flagWriteReq[1]) begin
        flags_q.n <= aluFlags[FLAG_N];
        flags_q.z <= aluFlags[FLAG_Z];
      end
      if (flagWriteReq[0]) begin
        flags_q.c <= aluFlags[FLAG_C];
        flags_q.v <= aluFlags[FLAG_V];
      end
    end
  end

  // Block FSM state, counter, stored condition and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
      it_cond <= 4'b0000;
      it_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
      it_cond <= it_cond_nxt;
      it_err  <= it_err_nxt;
    end
  end

  // Next-state logic; every accepted block member consumes one slot
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    it_cond_nxt = it_cond;
    it_err_nxt  = it_err;
    case (state)
      IDLE: begin
        if (accept && itStart && (itLen != '0)) begin
          state_nxt   = ACTIVE;
          it_cond_nxt = itCond;
          counter_nxt = (itLen > MAX_CNT) ? MAX_CNT : itLen;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACTIVE: begin
        if (accept) begin
          if (itStart) begin
            it_err_nxt = 1'b1;
          end else begin
            it_err_nxt = it_err;
          end
          // A taken branch leaves the block's instruction stream entirely
          if (PCSrc || (counter <= CNT_W'(1))) begin
            counter_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            counter_nxt = counter - CNT_W'(1);
          end
        end else begin
          state_nxt = ACTIVE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        counter_nxt = '0;
      end
    endcase
  end

endmodule

// File: doc/cond_exec_unit.md
# cond_exec_unit

Parametrised conditional-execution unit for the processor's execute stage. Holds the architectural NZCV flag register with per-group write enables and evaluates a 4-bit condition field against it. Gates PCSrc/RegWrite/MemWrite for each retiring instruction. Adds a predicated-block mode: one control instruction places the next N instructions under a single stored condition. A counter-driven state machine tracks the block.

## Interface
Parameters:
- MAX_IT, 4, maximum predicated-block length in instructions (≥1)
- CNT_W, $clog2(MAX_IT+1), width of block length/counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instrValid  in  1  an instruction occupies the stage this cycle
- stall  in  1  stage frozen; no state change, all gated outputs 0
- cond  in  4  instruction condition field (cond_e encoding)
- pcsReq / regWReq / memWReq  in  1 each  ungated branch / register-write / memory-write requests from decode
- flagWriteReq  in  2  [1]=update N,Z; [0]=update C,V
- aluFlags  in  4  ALU result flags {N,Z,C,V}
- itStart  in  1  instruction is a predicated-block opener
- itCond  in  4  condition applied to the block
- itLen  in  CNT_W  number of following instructions in the block
- PCSrc / RegWrite / MemWrite  out  1 each  gated requests
- condEx  out  1  current instruction executes
- flags  out  4  registered {N,Z,C,V}
- itActive  out  1  block in progress
- itRemaining  out  CNT_W  instructions left in block
- itErr  out  1  sticky: itStart received while block active

## Operation
- accept = instrValid & ~stall.
- Effective condition: the stored itCond while itActive, else cond.
- condHolds: standard ARM semantics: EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V, HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1. Encoding 1111 (NV) never holds.
- condEx = accept & condHolds & ~itStart.
- PCSrc = pcsReq & condEx; RegWrite = regWReq & condEx; MemWrite = memWReq & condEx.
- Flag register: on an edge with condEx, flags[3:2] <= aluFlags[3:2] if flagWriteReq[1]; flags[1:0] <= aluFlags[1:0] if flagWriteReq[0].
- An itStart instruction never writes flags or issues requests.
- States: IDLE, ACTIVE.
  - IDLE → ACTIVE on accept & itStart & itLen≠0. Latch itCond; counter <= min(itLen, MAX_IT).
  - accept & itStart & itLen=0 in IDLE: no-op.
  - ACTIVE: each accept decrements the counter, whether or not the instruction's condition holds. Counter reaching 0 → IDLE.
  - A taken branch (PCSrc=1) in ACTIVE forces counter to 0 → IDLE on that edge.
  - itStart accepted in ACTIVE: ignored as an opener, treated as a non-executing block member (decrements), and sets itErr.
- itActive = (state==ACTIVE); itRemaining = counter.

## Timing
- condEx and the gated outputs are combinational from inputs plus registered state: zero latency.
- Flag writes become visible from the next cycle. Inside a block, instruction k+1 evaluates against flags written by instruction k.
- itActive rises the cycle after the opener is accepted.
- stall=1 or instrValid=0 holds all registers.
- reset asserted (any time, including mid-block):
  - flags=0000, state IDLE, counter 0, itErr 0 immediately.
  - Outputs go 0 except those driven combinationally by inputs under AL/flag-true conditions.
  - With all inputs 0, every output is 0.
- itErr clears only on reset.

## Structure
- Package cond_pkg:
  - cond_e enum (EQ=0000 … AL=1110, NV=1111)
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - packed flags_t struct
  - it_state_e enum {IDLE, ACTIVE}
- Sub-module cond_check: combinational, cond_e + flags_t → holds. Reused by the branch predictor verification model.
- Top holds the flag register, the block FSM/counter and the gating.

## Test plan
- Reset, then instrValid=1, cond=EQ, regWReq=1, flags=0000 → RegWrite=0. Same with cond=AL → RegWrite=1.
- Instruction A: cond=AL, flagWriteReq=10, aluFlags=0100. Next instruction: cond=EQ, memWReq=1 → flags=0100 next cycle and MemWrite=1. Partial write: flagWriteReq=01, aluFlags=1011 → flags=0111.
- Opener itStart, itCond=NE, itLen=3, flags Z=1; then 3 instructions with regWReq=1 → RegWrite=0 for all three, itRemaining 3→2→1→0, itActive drops after third. Fourth instruction with cond=AL → RegWrite=1.
- itLen=7 with MAX_IT=4 → block lasts exactly 4 instructions. Second itStart mid-block → itErr=1, no opener effect. Stall inside block → itRemaining unchanged.
- Block itLen=4: second member has pcsReq=1 with condition true → PCSrc=1, itActive=0 next cycle.
- reset asserted mid-block, asynchronously between edges → itActive, itRemaining, flags, itErr all 0 without waiting for clk.
